// File: rtl/sb_stream_arbiter_if.sv
// Stream bundle shared by N requesters and one merged switchboard output.
// The arbiter takes the slave view; the surrounding datapath takes the master view.
interface sb_stream_arbiter_if #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 256
) ();
    logic [N*DW-1:0] in_data;
    logic [N*32-1:0] in_dest;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;

    logic [DW-1:0]   out_data;
    logic [31:0]     out_dest;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    logic [N-1:0]    grant;
    logic            busy;

    modport slave (
        input  in_data, in_dest, in_last, in_valid,
        output in_ready,
        output out_data, out_dest, out_last, out_valid,
        input  out_ready,
        output grant, busy
    );

    modport master (
        output in_data, in_dest, in_last, in_valid,
        input  in_ready,
        input  out_data, out_dest, out_last, out_valid,
        output out_ready,
        input  grant, busy
    );
endinterface

// File: rtl/sb_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging N streams onto one registered output.
// A requester keeps the grant from its first beat until its last=1 beat is accepted.
module sb_stream_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 256
) (
    input  logic               clk,
    input  logic               nreset,
    sb_stream_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] w_owner_next;

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [31:0]   r_out_dest;
    logic          r_out_last;

    logic          w_space;
    logic          w_sel_vld;
    logic [PW-1:0] w_sel;
    logic [PW-1:0] w_idx;
    logic [DW-1:0] w_sel_data;
    logic [31:0]   w_sel_dest;
    logic          w_sel_last;
    logic          w_sel_valid;
    logic          w_accept;
    logic [N-1:0]  w_in_ready;
    logic [N-1:0]  w_grant;

    // Nothing may be accepted while reset is asserted, so in_ready stays low then.
    assign w_space = nreset && (!r_out_valid || bus.out_ready);

    // Pick the requester: the owner while locked, else first valid searching from r_ptr.
    always_comb begin
        w_sel     = r_owner;
        w_sel_vld = 1'b0;
        w_idx     = '0;
        if (r_state == StLocked) begin
            w_sel_vld = 1'b1;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                w_idx = PW'((32'(r_ptr) + k) % N);
                if (!w_sel_vld && bus.in_valid[w_idx]) begin
                    w_sel_vld = 1'b1;
                    w_sel     = w_idx;
                end
            end
        end
    end

    // Route the selected requester's beat and derive per-requester ready and grant.
    always_comb begin
        w_sel_data  = '0;
        w_sel_dest  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        w_in_ready  = '0;
        w_grant     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_sel == PW'(i)) begin
                w_sel_data  = bus.in_data[i*DW +: DW];
                w_sel_dest  = bus.in_dest[i*32 +: 32];
                w_sel_last  = bus.in_last[i];
                w_sel_valid = bus.in_valid[i];
            end
            w_in_ready[i] = w_sel_vld && w_space && (w_sel == PW'(i));
            w_grant[i]    = (r_state == StLocked) && (r_owner == PW'(i));
        end
    end

    assign w_accept = w_sel_vld && w_space && w_sel_valid;

    // Lock on a non-final beat, release and advance the pointer on a final beat.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        if (w_accept) begin
            if (w_sel_last) begin
                w_state_next = StIdle;
                w_ptr_next   = (w_sel == PW'(N - 1)) ? '0 : w_sel + 1'b1;
            end else begin
                w_state_next = StLocked;
                w_owner_next = w_sel;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_owner <= w_owner_next;
        end
    end

    // Output register: load on accept, drop valid once the held beat is taken.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_dest  <= w_sel_dest;
            r_out_last  <= w_sel_last;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_dest  = r_out_dest;
    assign bus.out_last  = r_out_last;
    assign bus.grant     = w_grant;
    assign bus.busy      = (r_state == StLocked);
endmodule

// File: tb/tb_sb_stream_arbiter.sv
// Bench for sb_stream_arbiter: a 2-requester and a 4-requester instance fed from beat
// queues, checked every cycle against a packet-level model plus directed literals.
module tb_sb_stream_arbiter;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] dest;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    sb_stream_arbiter_if #(.N(2), .DW(DW)) bus2 ();
    sb_stream_arbiter_if #(.N(4), .DW(DW)) bus4 ();

    sb_stream_arbiter #(.N(2), .DW(DW)) dut2 (.clk(clk), .nreset(nreset), .bus(bus2));
    sb_stream_arbiter #(.N(4), .DW(DW)) dut4 (.clk(clk), .nreset(nreset), .bus(bus4));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Queues 0..1 feed the 2-way instance, 4..7 feed the 4-way instance.
    beat_t       q[8][$];
    logic [7:0]  fire;
    logic [31:0] obs_data[2][$];
    logic [31:0] obs_dest[2][$];
    int          obs_cyc[2][$];
    logic [31:0] exp_q[$];

    logic [3:0][31:0] dat2, dst2, dat4, dst4;
    assign dat2 = {64'b0, bus2.in_data};
    assign dst2 = {64'b0, bus2.in_dest};
    assign dat4 = bus4.in_data;
    assign dst4 = bus4.in_dest;

    // Model state per instance: round-robin pointer, packet owner, output register.
    int          m_ptr[2];
    bit          m_lock[2];
    int          m_owner[2];
    bit          m_ov[2];
    logic [31:0] m_od[2];
    logic [31:0] m_odst[2];
    bit          m_ol[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input logic [31:0] data, input logic [31:0] dest,
                        input logic last);
        beat_t b;
        b.data = data;
        b.dest = dest;
        b.last = last;
        q[idx].push_back(b);
    endtask

    task automatic drive_all();
        for (int i = 0; i < 2; i++) begin
            bus2.in_valid[i]         = q[i].size() > 0;
            bus2.in_data[i*32 +: 32] = (q[i].size() > 0) ? q[i][0].data : 32'h0;
            bus2.in_dest[i*32 +: 32] = (q[i].size() > 0) ? q[i][0].dest : 32'h0;
            bus2.in_last[i]          = (q[i].size() > 0) ? q[i][0].last : 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid[i]         = q[4+i].size() > 0;
            bus4.in_data[i*32 +: 32] = (q[4+i].size() > 0) ? q[4+i][0].data : 32'h0;
            bus4.in_dest[i*32 +: 32] = (q[4+i].size() > 0) ? q[4+i][0].dest : 32'h0;
            bus4.in_last[i]          = (q[4+i].size() > 0) ? q[4+i][0].last : 1'b0;
        end
    endtask

    // Sources: a beat leaves its queue once it has been handshaken.
    initial begin
        drive_all();
        forever begin
            @(negedge clk);
            fire = {bus4.in_valid & bus4.in_ready, 2'b00, bus2.in_valid & bus2.in_ready};
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                if (fire[i]) void'(q[i].pop_front());
            end
            drive_all();
        end
    end

    task automatic check_dut(input int d, input int n, input logic [3:0] vld,
                             input logic [3:0] lst, input logic [3:0] rdy,
                             input logic [3:0][31:0] dat, input logic [3:0][31:0] dst,
                             input logic ov, input logic [31:0] od, input logic [31:0] odst,
                             input logic ol, input logic oready, input logic [3:0] gnt,
                             input logic bsy);
        int         sel;
        bit         space;
        logic [3:0] e_rdy;
        logic [3:0] e_gnt;
        string      tag;
        tag = $sformatf("n%0d", n);
        if (!nreset) begin
            m_ptr[d] = 0; m_lock[d] = 0; m_owner[d] = 0;
            m_ov[d] = 0; m_od[d] = 0; m_odst[d] = 0; m_ol[d] = 0;
        end
        chk({tag, " out_valid"}, 32'(ov), 32'(m_ov[d]));
        chk({tag, " out_data"}, od, m_od[d]);
        chk({tag, " out_dest"}, odst, m_odst[d]);
        chk({tag, " out_last"}, 32'(ol), 32'(m_ol[d]));
        // Who may send now: the packet owner, or first valid requester from the pointer.
        sel = -1;
        if (m_lock[d]) begin
            sel = m_owner[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                if (sel < 0 && vld[(m_ptr[d] + k) % n]) sel = (m_ptr[d] + k) % n;
            end
        end
        space = nreset && (!m_ov[d] || oready);
        e_rdy = (sel >= 0 && space) ? 4'(1 << sel) : 4'b0;
        e_gnt = m_lock[d] ? 4'(1 << m_owner[d]) : 4'b0;
        chk({tag, " in_ready"}, 32'(rdy), 32'(e_rdy));
        chk({tag, " grant"}, 32'(gnt), 32'(e_gnt));
        chk({tag, " busy"}, 32'(bsy), 32'(m_lock[d]));
        if (!nreset) return;
        if (ov && oready) begin
            obs_data[d].push_back(od);
            obs_dest[d].push_back(odst);
            obs_cyc[d].push_back(cyc);
        end
        if (sel >= 0 && space && vld[sel]) begin
            m_ov[d]   = 1;
            m_od[d]   = dat[sel];
            m_odst[d] = dst[sel];
            m_ol[d]   = lst[sel];
            if (lst[sel]) begin
                m_lock[d] = 0;
                m_ptr[d]  = (sel + 1) % n;
            end else begin
                m_lock[d]  = 1;
                m_owner[d] = sel;
            end
        end else if (oready) begin
            m_ov[d] = 0;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cyc++;
        check_dut(0, 2, {2'b0, bus2.in_valid}, {2'b0, bus2.in_last}, {2'b0, bus2.in_ready},
                  dat2, dst2, bus2.out_valid, bus2.out_data, bus2.out_dest, bus2.out_last,
                  bus2.out_ready, {2'b0, bus2.grant}, bus2.busy);
        check_dut(1, 4, bus4.in_valid, bus4.in_last, bus4.in_ready, dat4, dst4,
                  bus4.out_valid, bus4.out_data, bus4.out_dest, bus4.out_last,
                  bus4.out_ready, bus4.grant, bus4.busy);
    end

    task automatic check_obs(input string name, input int d, input bit use_dest);
        chk({name, " count"}, 32'(obs_data[d].size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_data[d].size(); i++) begin
            if (use_dest) chk($sformatf("%s dest[%0d]", name, i), obs_dest[d][i], exp_q[i]);
            else chk($sformatf("%s data[%0d]", name, i), obs_data[d][i], exp_q[i]);
        end
    endtask

    task automatic wait_idle(input string name);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            done = 1;
            for (int i = 0; i < 8; i++) if (q[i].size() != 0) done = 0;
            if (bus2.out_valid || bus4.out_valid) done = 0;
        end
        chk({name, " drained"}, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_busy[3];
        logic [31:0] exp_gnt[3];
        logic [31:0] exp_r1[3];
        bus2.out_ready = 1'b1;
        bus4.out_ready = 1'b1;
        nreset = 1'b0;

        // Reset with both requesters valid, then round-robin single-beat packets.
        for (int s = 0; s < 4; s++) begin
            push(0, 32'h000 + 32'(s), 32'd0, 1'b1);
            push(1, 32'h100 + 32'(s), 32'd1, 1'b1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_valid", 32'(bus2.in_valid), 32'h3);
        chk("reset in_ready", 32'(bus2.in_ready), 32'h0);
        chk("reset out_valid", 32'(bus2.out_valid), 32'h0);
        chk("reset grant", 32'(bus2.grant), 32'h0);
        chk("reset busy", 32'(bus2.busy), 32'h0);
        @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        chk("first pick", 32'(bus2.in_ready), 32'h1);
        @(negedge clk);
        chk("first out_valid", 32'(bus2.out_valid), 32'h1);
        chk("first out_data", bus2.out_data, 32'h000);
        wait_idle("rr");
        exp_q = '{32'h000, 32'h100, 32'h001, 32'h101, 32'h002, 32'h102, 32'h003, 32'h103};
        check_obs("rr", 0, 1'b0);
        if (obs_cyc[0].size() == 8) chk("rr throughput", 32'(obs_cyc[0][7] - obs_cyc[0][0]), 32'd7);
        else chk("rr throughput samples", 32'(obs_cyc[0].size()), 32'd8);

        // Packet atomicity: 3-beat packet from requester 0 while requester 1 waits.
        obs_data[0].delete();
        obs_dest[0].delete();
        obs_cyc[0].delete();
        push(0, 32'h10, 32'd0, 1'b0);
        push(0, 32'h11, 32'd0, 1'b0);
        push(0, 32'h12, 32'd0, 1'b1);
        push(1, 32'h20, 32'd1, 1'b1);
        @(negedge clk);
        chk("atom start ready", 32'(bus2.in_ready), 32'h1);
        chk("atom start busy", 32'(bus2.busy), 32'h0);
        exp_busy = '{32'd1, 32'd1, 32'd0};
        exp_gnt  = '{32'h1, 32'h1, 32'h0};
        exp_r1   = '{32'd0, 32'd0, 32'd1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("atom busy[%0d]", k), 32'(bus2.busy), exp_busy[k]);
            chk($sformatf("atom grant[%0d]", k), 32'(bus2.grant), exp_gnt[k]);
            chk($sformatf("atom ready1[%0d]", k), 32'(bus2.in_ready[1]), exp_r1[k]);
        end
        wait_idle("atom");
        exp_q = '{32'h10, 32'h11, 32'h12, 32'h20};
        check_obs("atom", 0, 1'b0);

        // Backpressure for 5 cycles in the middle of a 4-beat packet.
        obs_data[0].delete();
        obs_dest[0].delete();
        for (int s = 0; s < 4; s++) push(1, 32'h30 + 32'(s), 32'd1, s == 3);
        repeat (3) @(posedge clk);
        #1 bus2.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall out_data", bus2.out_data, 32'h31);
            chk("stall out_dest", bus2.out_dest, 32'd1);
            chk("stall out_last", 32'(bus2.out_last), 32'd0);
            chk("stall out_valid", 32'(bus2.out_valid), 32'd1);
            chk("stall in_ready", 32'(bus2.in_ready), 32'h0);
        end
        @(posedge clk);
        #1 bus2.out_ready = 1'b1;
        wait_idle("stall");
        exp_q = '{32'h30, 32'h31, 32'h32, 32'h33};
        check_obs("stall", 0, 1'b0);

        // Pointer wrap on the 4-way instance with only requesters 3 and 0 active.
        push(7, 32'h300, 32'd3, 1'b1);
        push(7, 32'h301, 32'd3, 1'b1);
        push(4, 32'h000, 32'd0, 1'b1);
        push(4, 32'h001, 32'd0, 1'b1);
        wait_idle("wrap");
        exp_q = '{32'h000, 32'h300, 32'h001, 32'h301};
        check_obs("wrap", 1, 1'b0);
        exp_q = '{32'd0, 32'd3, 32'd0, 32'd3};
        check_obs("wrap", 1, 1'b1);

        // Asynchronous reset after beat 2 of a 4-beat packet from requester 1.
        obs_data[0].delete();
        obs_dest[0].delete();
        for (int s = 0; s < 4; s++) push(1, 32'h40 + 32'(s), 32'd1, s == 3);
        repeat (3) @(posedge clk);
        #1 nreset = 1'b0;
        #1;
        chk("mid-rst busy", 32'(bus2.busy), 32'd0);
        chk("mid-rst out_valid", 32'(bus2.out_valid), 32'd0);
        chk("mid-rst grant", 32'(bus2.grant), 32'h0);
        q[0].delete();
        q[1].delete();
        obs_data[0].delete();
        obs_dest[0].delete();
        push(0, 32'h50, 32'd0, 1'b1);
        push(1, 32'h60, 32'd1, 1'b1);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        chk("post-rst pick", 32'(bus2.in_ready), 32'h1);
        wait_idle("post-rst");
        exp_q = '{32'h50, 32'h60};
        check_obs("post-rst", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sb_stream_arbiter.md
Name: sb_stream_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one switchboard stream port (data/dest/last/valid/ready) between N requester streams.
- Sits in front of an sb_tx_sim-style sink. Multiple testbench datapaths (packet modifiers, generators) feed one queue.
- A grant locks to one requester from the first beat to the beat with last=1; packets are never interleaved.
- The output is registered: one pipeline stage with full-throughput handshake.

Parameters:
- N, 2, number of requester streams (>=2).
- DW, 256, data width per beat.

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous active-low reset.
- in_data  input  N*DW  requester data; requester i occupies [i*DW +: DW].
- in_dest  input  N*32  requester dest; requester i occupies [i*32 +: 32].
- in_last  input  N  per-requester end-of-packet flag.
- in_valid  input  N  per-requester valid.
- in_ready  output  N  per-requester ready.
- out_data  output  DW  merged stream data (registered).
- out_dest  output  32  merged stream dest (registered).
- out_last  output  1  merged stream last (registered).
- out_valid  output  1  merged stream valid (registered).
- out_ready  input  1  downstream ready.
- grant  output  N  one-hot owner while a packet is in progress; 0 when idle.
- busy  output  1  1 while in LOCKED.

Behaviour:
- Reset (nreset low, async):
  - state=IDLE, ptr=0, owner=0.
  - out_valid=0, out_data=0, out_dest=0, out_last=0.
  - grant=0, busy=0, in_ready=0.
- Output stage: space = !out_valid || out_ready. The out_* registers load when a beat is accepted. out_valid clears when out_ready=1 and no new beat is accepted that cycle.
- Accept rule:
  - in_ready[i] = space && (sel == i), where sel is the current selected requester.
  - A beat transfers on in_valid[i] && in_ready[i].
  - Latency is exactly 1 cycle input-to-output. Throughput is 1 beat/cycle when out_ready is held high.
- State IDLE:
  - sel = first i with in_valid[i]=1, searching i = ptr, ptr+1, ... N-1, 0, ... ptr-1 (combinational, same cycle).
  - No valid input: no selection, all in_ready=0, stay IDLE.
  - Selected beat accepted with last=1: stay IDLE; ptr = (sel+1) mod N.
  - Selected beat accepted with last=0: go to LOCKED; owner = sel.
  - Selected beat not accepted (space=0): stay IDLE; no state change; re-arbitrate next cycle.
- State LOCKED:
  - sel = owner. All other in_ready=0 regardless of their valid.
  - Owner's beat accepted with last=1: go to IDLE; ptr = (owner+1) mod N.
  - Owner valid low mid-packet: hold LOCKED indefinitely; no timeout.
- grant = onehot(owner) in LOCKED, else 0. busy = (state==LOCKED).
- ptr wrap: winner N-1 sets ptr to 0.
- Fairness: a requester continuously valid waits at most N-1 packets.
- Backpressure: while out_valid=1 and out_ready=0, out_* hold stable and all in_ready=0.
- Inputs from non-selected requesters are never consumed or modified. A requester may drop valid while not selected.
- Reset mid-packet: the in-flight output beat is discarded, the lock is released, and ptr returns to 0. Upstream senders are responsible for restarting.
- dest is passed through unchanged. No width conversion; no check on data content.

Test Plan:
- Reset: assert nreset=0 with all inputs valid -> out_valid=0, in_ready=0, grant=0, busy=0. Release nreset -> first accepted beat comes from requester 0.
- Round-robin (N=2): both requesters send single-beat packets continuously with out_ready=1; requester i sends data=i*0x100+seq -> output order 0x000, 0x100, 0x001, 0x101, ...; one beat per cycle; 1-cycle latency.
- Packet atomicity: requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is valid -> output is the 3 beats of requester 0, then requester 1; in_ready[1]=0 and grant=2'b01 throughout; busy=1 for beats 1-2 only.
- Backpressure: hold out_ready=0 for 5 cycles mid-packet -> out_data/out_dest/out_last stable and in_ready=0 during the stall; release -> no beat lost or duplicated (sequence-number check).
- Wrap (N=4): only requesters 3 and 0 valid with single-beat packets -> order 3,0,3,0 after the first win by 0 (ptr 0->1->0 wraps via 3); dest values 3 and 0 passed through unchanged.
- Async reset mid-packet: pulse nreset low after beat 2 of 4 from requester 1 -> busy=0, out_valid=0 immediately. Next arbitration starts at ptr=0 and selects requester 0 when both are valid.
